// File: rtl/mem_pkg.sv
// Shared encodings for the memory access sequencer: ops, address sources,
// fault codes, FSM states and the strobe bundle.
package mem_pkg;

  localparam logic [2:0] OP_FETCH = 3'b000;
  localparam logic [2:0] OP_LDB   = 3'b001;
  localparam logic [2:0] OP_LDW   = 3'b010;
  localparam logic [2:0] OP_STB   = 3'b011;
  localparam logic [2:0] OP_STW   = 3'b100;

  localparam logic [1:0] SRC_PC   = 2'b00;
  localparam logic [1:0] SRC_R6   = 2'b01;
  localparam logic [1:0] SRC_ALU  = 2'b10;
  localparam logic [1:0] SRC_RSVD = 2'b11;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_UNALIGNED = 2'b01;
  localparam logic [1:0] FC_RSVD_OP   = 2'b10;
  localparam logic [1:0] FC_RSVD_SRC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic ctrl;
    logic mdr_l;
    logic mdr_h;
    logic ir_wr;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '0;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of a memory request into its strobe set, plus
// legality classification (reserved op > reserved src > unaligned).
module mem_op_decode
  import mem_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] src,
  input  logic       addr_lsb,
  output strobe_t    strb,
  output logic       legal,
  output logic [1:0] fcode
);

  logic word_access;

  always_comb begin
    strb        = STROBE_IDLE;
    legal       = 1'b1;
    fcode       = FC_NONE;
    word_access = 1'b0;
    case (op)
      OP_FETCH: begin
        strb.mem_rd = 1'b1;
        strb.ir_wr  = 1'b1;
        word_access = 1'b1;
      end
      OP_LDB: begin
        strb.mem_rd = 1'b1;
        strb.mdr_l  = 1'b1;
      end
      OP_LDW: begin
        strb.mem_rd = 1'b1;
        strb.mdr_l  = 1'b1;
        strb.mdr_h  = 1'b1;
        word_access = 1'b1;
      end
      OP_STB: begin
        strb.mem_wr = 1'b1;
      end
      OP_STW: begin
        strb.mem_wr = 1'b1;
        strb.ctrl   = 1'b1;
        word_access = 1'b1;
      end
      default: ;
    endcase

    // Byte accesses may use odd addresses; memory picks the high byte itself.
    if (op > OP_STW) begin
      legal = 1'b0;
      fcode = FC_RSVD_OP;
    end else if (src == SRC_RSVD) begin
      legal = 1'b0;
      fcode = FC_RSVD_SRC;
    end else if (word_access && addr_lsb) begin
      legal = 1'b0;
      fcode = FC_UNALIGNED;
    end
  end

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: accepts one request at a time, holds registered
// strobes for ACCESS_CYCLES cycles, then reports done or fault.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_src,
  input  logic [15:0] req_addr,
  output logic        memRd,
  output logic        memWr,
  output logic        ctrl,
  output logic        mdr_l,
  output logic        mdr_h,
  output logic        ir_wr,
  output logic [1:0]  I,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  strobe_t    strb;
  strobe_t    dec_strb;
  logic       dec_legal;
  logic [1:0] dec_fcode;
  logic       addr_hi_unused;

  // Only the LSB matters here; the datapath routes the full address.
  assign addr_hi_unused = ^req_addr[15:1];

  mem_op_decode u_decode (
    .op       (req_op),
    .src      (req_src),
    .addr_lsb (req_addr[0]),
    .strb     (dec_strb),
    .legal    (dec_legal),
    .fcode    (dec_fcode)
  );

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      strb       <= STROBE_IDLE;
      I          <= SRC_PC;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (dec_legal) begin
              state <= ST_ACCESS;
              strb  <= dec_strb;
              I     <= req_src;
              cnt   <= CNT_LOAD;
            end else begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= dec_fcode;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd1) begin
            state <= ST_DONE;
            strb  <= STROBE_IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign memRd = strb.mem_rd;
  assign memWr = strb.mem_wr;
  assign ctrl  = strb.ctrl;
  assign mdr_l = strb.mdr_l;
  assign mdr_h = strb.mdr_h;
  assign ir_wr = strb.ir_wr;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: stimulus pushes expected outcomes,
// a negedge monitor pops and compares on every done/fault pulse.
module tb_mem_access_seq;

  localparam int AC = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [1:0]  req_src = 2'b00;
  logic [15:0] req_addr = 16'h0000;
  logic        memRd, memWr, ctrl, mdr_l, mdr_h, ir_wr;
  logic [1:0]  I;
  logic        done, fault;
  logic [1:0]  fault_code;

  mem_access_seq #(.ACCESS_CYCLES(AC)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src    (req_src),
    .req_addr   (req_addr),
    .memRd      (memRd),
    .memWr      (memWr),
    .ctrl       (ctrl),
    .mdr_l      (mdr_l),
    .mdr_h      (mdr_h),
    .ir_wr      (ir_wr),
    .I          (I),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       is_fault;
    bit [1:0] fc;
    bit [5:0] vec;   // {memRd, memWr, ctrl, mdr_l, mdr_h, ir_wr}
    bit [1:0] src;
    int       acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   legal_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour taken straight from the op table and fault priority.
  function automatic exp_t model(input bit [2:0] op, input bit [1:0] src, input bit [15:0] addr);
    exp_t e;
    bit   word;
    e.is_fault = 1'b0;
    e.fc = 2'b00;
    e.src = src;
    e.acc_cyc = 0;
    word = (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
    case (op)
      3'd0:    e.vec = 6'b100001;
      3'd1:    e.vec = 6'b100100;
      3'd2:    e.vec = 6'b100110;
      3'd3:    e.vec = 6'b010000;
      3'd4:    e.vec = 6'b011000;
      default: e.vec = 6'b000000;
    endcase
    if (op >= 3'd5) begin
      e.is_fault = 1'b1; e.fc = 2'b10;
    end else if (src == 2'b11) begin
      e.is_fault = 1'b1; e.fc = 2'b11;
    end else if (word && addr[0]) begin
      e.is_fault = 1'b1; e.fc = 2'b01;
    end
    return e;
  endfunction

  // Drive one request at the first negedge with req_ready, hold it one cycle.
  task automatic issue(input bit [2:0] op, input bit [1:0] src, input bit [15:0] addr, input bit push);
    exp_t e;
    int   k = 0;
    @(negedge clock);
    req_valid = 1'b0;
    while (!req_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
    end else begin
      req_valid = 1'b1;
      req_op = op;
      req_src = src;
      req_addr = addr;
      e = model(op, src, addr);
      e.acc_cyc = cyc;
      if (push) begin
        exp_q.push_back(e);
        if (!e.is_fault) legal_cnt++;
      end
      @(negedge clock);
      req_valid = 1'b0;
    end
  endtask

  // Random requests while busy; must be ignored and never queued.
  task automatic junk(input int n);
    for (int j = 0; j < n; j++) begin
      if (req_ready) req_valid = 1'b0;
      else begin
        req_valid = 1'($urandom);
        req_op = 3'($urandom);
        req_src = 2'($urandom);
        req_addr = 16'($urandom);
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor
  int       run_len = 0;
  bit [5:0] run_vec = '0;
  bit       run_changed = 0;
  bit [1:0] exp_fc = 2'b00;

  always @(negedge clock) begin
    logic [5:0] vec;
    exp_t e;
    vec = {memRd, memWr, ctrl, mdr_l, mdr_h, ir_wr};
    if (reset) begin
      run_len = 0;
      run_changed = 0;
      exp_fc = 2'b00;
    end else begin
      if (memRd && memWr) check("rd_wr_overlap", 32'(vec), 32'd0);
      if (ir_wr && (mdr_l || mdr_h)) check("ir_mdr_overlap", 32'(vec), 32'd0);
      if (memRd || memWr) begin
        if (run_len == 0) run_vec = vec;
        else if (vec != run_vec) run_changed = 1;
        run_len++;
      end
      if (done || fault) begin
        if (done && fault) check("done_and_fault", 32'(fault), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, done, fault}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_fault", 32'(fault), 32'(e.is_fault));
          if (done) begin
            done_cnt++;
            check("done_latency", 32'(cyc - e.acc_cyc), 32'(AC + 1));
            check("strobe_cycles", 32'(run_len), 32'(AC));
            check("strobe_vector", 32'(run_vec), 32'(e.vec));
            check("strobe_stable", 32'(run_changed), 32'd0);
            check("addr_sel_I", 32'(I), 32'(e.src));
            check("strobes_off_at_done", 32'(vec), 32'd0);
          end else begin
            check("fault_latency", 32'(cyc - e.acc_cyc), 32'd1);
            check("fault_no_strobes", 32'(run_len), 32'd0);
            check("fault_code", 32'(fault_code), 32'(e.fc));
            exp_fc = e.fc;
          end
        end
        run_len = 0;
        run_changed = 0;
      end else begin
        check("fault_code_hold", 32'(fault_code), 32'(exp_fc));
      end
    end
  end

  initial begin
    bit [2:0] op;
    bit [1:0] src;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_strobes", {26'd0, memRd, memWr, ctrl, mdr_l, mdr_h, ir_wr}, 32'd0);
    check("rst_done_fault", {30'd0, done, fault}, 32'd0);
    check("rst_I", 32'(I), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);

    issue(3'b000, 2'b00, 16'h0004, 1); wait_idle();
    issue(3'b001, 2'b10, 16'h0013, 1); wait_idle();
    issue(3'b010, 2'b10, 16'h0013, 1); wait_idle();
    issue(3'b100, 2'b01, 16'h0018, 1); junk(AC + 1); wait_idle();
    issue(3'b110, 2'b00, 16'h0000, 1); wait_idle();
    issue(3'b001, 2'b11, 16'h0000, 1); wait_idle();
    issue(3'b111, 2'b11, 16'h0001, 1); wait_idle();

    // Reset in the 2nd ACCESS cycle of a byte store.
    issue(3'b011, 2'b00, 16'h0021, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid_memWr", 32'(memWr), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    repeat (AC + 3) @(negedge clock);
    check("rstmid_no_late_done", 32'(done_cnt), 32'(legal_cnt));

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(5, 7));
      else op = 3'($urandom_range(0, 4));
      src = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(op, src, 16'($urandom), 1);
      junk($urandom_range(0, AC + 2));
    end
    wait_idle();
    repeat (3) @(negedge clock);
    check("done_count", 32'(done_cnt), 32'(legal_cnt));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer: the initiator side of the byte/word data memory port. It accepts one access request at a time from the control unit and decodes the operation (instruction fetch, byte/word load, byte/word store) into the memory strobes memRd, memWr, ctrl, mdr_l, mdr_h, ir_wr and I. It holds the strobes for a programmable number of cycles, checks word alignment, and reports completion or fault back to the control unit.

## Interface
- ACCESS_CYCLES, default 1: cycles strobes are held per access (legal range 1-15).
- clock  in  1  system clock; sequencer updates on posedge, memory samples on negedge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  3  000 FETCH, 001 LDB, 010 LDW, 011 STB, 100 STW, 101-111 reserved.
- req_src  in  2  address source: 00 PC, 01 R6, 10 AluOut; 11 reserved.
- req_addr  in  16  resolved address value, used only for alignment check.
- memRd, memWr  out  1  read / write strobes.
- ctrl  out  1  1 = word write, 0 = byte write.
- mdr_l, mdr_h  out  1  MDR lane enables: LDW = 1/1, LDB = 1/0.
- ir_wr  out  1  IR load enable (FETCH only).
- I  out  2  address select, registered copy of req_src.
- done  out  1  one-cycle pulse, access finished.
- fault  out  1  one-cycle pulse, access rejected; no strobes issued.
- fault_code  out  2  01 unaligned, 10 reserved op, 11 reserved src; held until next fault.

## Operation
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE: req_ready=1. On req_valid, capture op, src and addr[0]. Classify with this priority: reserved op, then reserved src, then unaligned. Unaligned means FETCH/LDW/STW with addr[0]=1. Faulting requests go to FAULT, all others to ACCESS.
- ACCESS: drive decoded strobes and I for ACCESS_CYCLES cycles using a 4-bit down-counter, then go to DONE.
  - FETCH: memRd=1, ir_wr=1.
  - LDB: memRd=1, mdr_l=1.
  - LDW: memRd=1, mdr_l=1, mdr_h=1.
  - STB: memWr=1, ctrl=0.
  - STW: memWr=1, ctrl=1.
- DONE: done=1, all strobes 0, go to IDLE.
- FAULT: fault=1, fault_code updated, strobes 0, go to IDLE.
- memRd and memWr are never asserted together. ir_wr and mdr_l/mdr_h are never asserted together.
- Byte accesses at odd addresses are legal (memory selects the high byte).
- req_valid while not in IDLE is ignored and not queued.

## Timing
- Request accepted on the posedge where req_valid & req_ready.
- Strobes go high in the next cycle and are held stable across ACCESS_CYCLES negedges.
- done is asserted ACCESS_CYCLES+1 cycles after acceptance. Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- fault is asserted 1 cycle after acceptance.
- Reset: state IDLE, counter 0. All strobes, done and fault are 0; I=00, fault_code=00, req_ready=1 in the cycle after reset.
- Reset mid-ACCESS: strobes drop at the next posedge, no done pulse, and the partial access is abandoned.
- Strobe outputs are registered, with no combinational path from req_* to strobes.

## Structure
- Shared package mem_pkg: op encodings, src encodings, fault codes, state enum.
- One sub-module, mem_op_decode: combinational op → strobe vector and legality.

## Test plan
- Reset, then FETCH src=00 addr=0x0004, ACCESS_CYCLES=1 → memRd=ir_wr=1 for exactly 1 cycle, I=00, done 2 cycles after accept.
- LDB src=10 addr=0x0013 → memRd=1, mdr_l=1, mdr_h=0, I=10, no fault. Repeat as LDW addr=0x0013 → fault=1, fault_code=01, no memRd ever high.
- STW src=01 addr=0x0018, ACCESS_CYCLES=3 → memWr=1, ctrl=1 for 3 cycles, done on cycle 4; req_valid pulses during ACCESS are ignored.
- req_op=110 → fault, fault_code=10. req_op=001 with req_src=11 → fault_code=11. req_op=111 with req_src=11 → fault_code=10 (op has priority).
- Reset asserted in the 2nd ACCESS cycle of STB (ACCESS_CYCLES=3) → memWr=0 the next cycle, no done, req_ready=1.
- Random legal stream of 200 ops → scoreboard checks strobe one-hot rules and done count equals accepted legal requests.
